// File: rtl/rip_axi_mem_slave_if.sv
// rip_axi_mem_slave_if -- AXI4 bundle between a master and the memory-model slave.
//   slave  modport: AW/W/AR request inputs, B/R response outputs.
//   master modport: the mirror image, plus the AW/AR sideband (lock, cache,
//                   prot, qos, region). The slave ignores the sideband, so its
//                   modport leaves it out.
interface rip_axi_mem_slave_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_DATA_WIDTH = 32
);
  localparam int NB = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   AWID;
  logic [ADDR_WIDTH-1:0]     AWADDR;
  logic [7:0]                AWLEN;
  logic [2:0]                AWSIZE;
  logic [1:0]                AWBURST;
  logic                      AWLOCK;
  logic [3:0]                AWCACHE;
  logic [2:0]                AWPROT;
  logic [3:0]                AWQOS;
  logic [3:0]                AWREGION;
  logic                      AWVALID;
  logic                      AWREADY;

  logic [AXI_DATA_WIDTH-1:0] WDATA;
  logic [NB-1:0]             WSTRB;
  logic                      WLAST;
  logic                      WVALID;
  logic                      WREADY;

  logic [AXI_ID_WIDTH-1:0]   BID;
  logic [1:0]                BRESP;
  logic                      BVALID;
  logic                      BREADY;

  logic [AXI_ID_WIDTH-1:0]   ARID;
  logic [ADDR_WIDTH-1:0]     ARADDR;
  logic [7:0]                ARLEN;
  logic [2:0]                ARSIZE;
  logic [1:0]                ARBURST;
  logic                      ARLOCK;
  logic [3:0]                ARCACHE;
  logic [2:0]                ARPROT;
  logic [3:0]                ARQOS;
  logic [3:0]                ARREGION;
  logic                      ARVALID;
  logic                      ARREADY;

  logic [AXI_ID_WIDTH-1:0]   RID;
  logic [AXI_DATA_WIDTH-1:0] RDATA;
  logic [1:0]                RRESP;
  logic                      RLAST;
  logic                      RVALID;
  logic                      RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT,
           AWQOS, AWREGION, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT,
           ARQOS, ARREGION, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );
endinterface

// File: rtl/rip_axi_mem_slave.sv
// rip_axi_mem_slave -- AXI4 slave memory model (simulation stand-in for DDR/PS).
//   clk : sole clock, rising edge
//   rst : synchronous, active-high reset
//   axi : rip_axi_mem_slave_if.slave -- AW/W/B/AR/R channels
// Independent write and read FSMs, one outstanding burst each. FIXED/INCR
// bursts with SIZE == log2(bytes per beat) are legal; anything else, or a beat
// outside [BASE_ADDR, BASE_ADDR + MEM_DEPTH*NB), answers SLVERR.
// Optional build macro RIP_AXI_MEM_SLAVE_STALL_EN: LFSR-driven random stalls
// on AWREADY/WREADY/ARREADY and R beat launch.
module rip_axi_mem_slave #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    AXI_ID_WIDTH   = 4,
  parameter int                    AXI_DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH      = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input logic                clk,
  input logic                rst,
  rip_axi_mem_slave_if.slave axi
);
  localparam int NB  = AXI_DATA_WIDTH / 8;
  localparam int LNB = $clog2(NB);
  localparam int IW  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-LNB-1:0] DEPTH_W = (ADDR_WIDTH-LNB)'(MEM_DEPTH);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
  localparam logic [1:0] B_FIXED = 2'b00, B_INCR = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  // Latched burst context; addr/cnt always describe the next beat to handle.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [7:0]            cnt;
    logic                  fixed;
    logic                  bad;
  } burst_t;

  function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
    return (burst != B_FIXED && burst != B_INCR) || (size != 3'(LNB));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic fixed);
    return fixed ? a : a + ADDR_WIDTH'(NB);
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic    rst_q, stall, hold;
  wstate_t w_st, w_nxt;
  rstate_t r_st, r_nxt;
  logic    aw_rdy, w_rdy, b_vld, ar_rdy;
  logic    aw_hs, w_hs, ar_hs, launch;
  burst_t  w_ctx, r_ctx, ld;
  logic    b_err, w_last_beat, w_beat_err, w_oor, ld_oor, ld_err;
  logic [ADDR_WIDTH:0]       w_off, ld_off;   // extra MSB = below BASE_ADDR
  logic [IW-1:0]             w_idx, ld_idx;
  logic [AXI_ID_WIDTH-1:0]   bid, rid;
  logic [1:0]                bresp, rresp;
  logic [AXI_DATA_WIDTH-1:0] rdata;
  logic                      rvalid, rlast;
  logic                      unused_addr_bits;

`ifdef RIP_AXI_MEM_SLAVE_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Readies stay low during reset and for one cycle after it.
  always_ff @(posedge clk) rst_q <= rst;
  assign hold = rst | rst_q | stall;

  // ---------------- write channel ----------------
  always_ff @(posedge clk) begin
    if (rst) w_st <= W_IDLE;
    else     w_st <= w_nxt;
  end

  always_comb begin
    w_nxt  = w_st;
    aw_rdy = 1'b0;
    w_rdy  = 1'b0;
    b_vld  = 1'b0;
    unique case (w_st)
      W_IDLE: begin
        aw_rdy = !hold;
        if (!hold && axi.AWVALID) w_nxt = W_DATA;
      end
      W_DATA: begin
        w_rdy = !hold;
        if (!hold && axi.WVALID && w_last_beat) w_nxt = W_RESP;
      end
      W_RESP: begin
        b_vld = 1'b1;
        if (axi.BREADY) w_nxt = W_IDLE;
      end
      default: w_nxt = W_IDLE;
    endcase
  end

  assign aw_hs       = axi.AWVALID && aw_rdy;
  assign w_hs        = axi.WVALID && w_rdy;
  assign w_last_beat = (w_ctx.cnt == w_ctx.len);
  assign w_off       = {1'b0, w_ctx.addr} - {1'b0, BASE_ADDR};
  assign w_oor       = w_off[ADDR_WIDTH] || (w_off[ADDR_WIDTH-1:LNB] >= DEPTH_W);
  assign w_idx       = w_off[LNB +: IW];
  // A WLAST early or missing only poisons the response; the count ends the burst.
  assign w_beat_err  = w_ctx.bad || w_oor || (axi.WLAST != w_last_beat);

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ctx <= '0;
      b_err <= 1'b0;
      bid   <= '0;
      bresp <= OKAY;
    end else if (aw_hs) begin
      w_ctx <= '{addr: axi.AWADDR, len: axi.AWLEN, cnt: 8'd0,
                 fixed: (axi.AWBURST == B_FIXED),
                 bad: burst_bad(axi.AWBURST, axi.AWSIZE)};
      b_err <= 1'b0;
      bid   <= axi.AWID;
    end else if (w_hs) begin
      w_ctx.addr <= next_addr(w_ctx.addr, w_ctx.fixed);
      w_ctx.cnt  <= w_ctx.cnt + 8'd1;
      b_err      <= b_err | w_beat_err;
      if (w_last_beat) bresp <= (b_err | w_beat_err) ? SLVERR : OKAY;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !w_ctx.bad && !w_oor)
      for (int b = 0; b < NB; b++)
        if (axi.WSTRB[b]) mem[w_idx][b*8 +: 8] <= axi.WDATA[b*8 +: 8];
  end

  // ---------------- read channel ----------------
  always_ff @(posedge clk) begin
    if (rst) r_st <= R_IDLE;
    else     r_st <= r_nxt;
  end

  always_comb begin
    r_nxt  = r_st;
    ar_rdy = 1'b0;
    unique case (r_st)
      R_IDLE: begin
        ar_rdy = !hold;
        if (!hold && axi.ARVALID) r_nxt = R_DATA;
      end
      R_DATA: if (rvalid && axi.RREADY && rlast) r_nxt = R_IDLE;
      default: r_nxt = R_IDLE;
    endcase
  end

  assign ar_hs = axi.ARVALID && ar_rdy;

  // Beat source: the AR request itself on acceptance, else the latched context.
  always_comb begin
    ld = r_ctx;
    if (r_st == R_IDLE)
      ld = '{addr: axi.ARADDR, len: axi.ARLEN, cnt: 8'd0,
             fixed: (axi.ARBURST == B_FIXED),
             bad: burst_bad(axi.ARBURST, axi.ARSIZE)};
  end

  // Launch the next beat when the output register is empty or being drained.
  assign launch = (r_st == R_IDLE) ? ar_hs
                                   : ((!rvalid || (axi.RREADY && !rlast)) && !stall);
  assign ld_off = {1'b0, ld.addr} - {1'b0, BASE_ADDR};
  assign ld_oor = ld_off[ADDR_WIDTH] || (ld_off[ADDR_WIDTH-1:LNB] >= DEPTH_W);
  assign ld_idx = ld_off[LNB +: IW];
  assign ld_err = ld.bad || ld_oor;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctx  <= '0;
      rid    <= '0;
      rvalid <= 1'b0;
      rlast  <= 1'b0;
      rdata  <= '0;
      rresp  <= OKAY;
    end else begin
      if (ar_hs) rid <= axi.ARID;
      if (launch) begin
        rvalid <= 1'b1;
        rlast  <= (ld.cnt == ld.len);
        rresp  <= ld_err ? SLVERR : OKAY;
        rdata  <= ld_err ? '0 : mem[ld_idx];
        r_ctx  <= '{addr: next_addr(ld.addr, ld.fixed), len: ld.len,
                    cnt: ld.cnt + 8'd1, fixed: ld.fixed, bad: ld.bad};
      end else if (rvalid && axi.RREADY) begin
        rvalid <= 1'b0;
        rlast  <= 1'b0;
      end
    end
  end

  // Sub-beat address bits carry no meaning for a word-addressed array.
  assign unused_addr_bits = ^{w_off, ld_off};

  assign axi.AWREADY = aw_rdy;
  assign axi.WREADY  = w_rdy;
  assign axi.BVALID  = b_vld;
  assign axi.BID     = bid;
  assign axi.BRESP   = bresp;
  assign axi.ARREADY = ar_rdy;
  assign axi.RVALID  = rvalid;
  assign axi.RLAST   = rlast;
  assign axi.RDATA   = rdata;
  assign axi.RRESP   = rresp;
  assign axi.RID     = rid;
endmodule
